// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM read arbiter: FSM states, default timing, index helper.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, REFRESH} arb_state_t;

  localparam int REFRESH_CYCLES_DEF = 1117;
  localparam int BURST_LEN_DEF      = 2;
  localparam int MAX_NREQ           = 8;
  localparam int IDX_W              = 3;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sdram_read_arbiter_if.sv
// Requester, command and response signals of the SDRAM read arbiter; master = arbiter side.
interface sdram_read_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        rd_valid;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_last;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_refresh;
  logic [ADDR_W-1:0]      cmd_addr;
  logic                   rsp_valid;
  logic [DATA_W-1:0]      rsp_data;
  logic                   busy;
  logic                   refresh_overrun;

  modport master (
    input  req, req_addr, cmd_ready, rsp_valid, rsp_data,
    output gnt, rd_valid, rd_data, rd_last, cmd_valid, cmd_refresh, cmd_addr,
           busy, refresh_overrun
  );

  modport slave (
    output req, req_addr, cmd_ready, rsp_valid, rsp_data,
    input  gnt, rd_valid, rd_data, rd_last, cmd_valid, cmd_refresh, cmd_addr,
           busy, refresh_overrun
  );
endinterface

// File: rtl/sdram_rr_picker.sv
// Combinational winner select: round-robin from ptr, or strict priority (req[0] highest)
// when SDRAM_ARB_FIXED_PRIO_EN is defined. Output is one-hot, zero when no request.
module sdram_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win
);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign win = req & (~req + 1'b1);
`else
  logic [NREQ-1:0] low;
  logic [NREQ-1:0] pick;

  // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
  assign low  = NREQ'({req, req} >> ptr);
  assign pick = low & (~low + 1'b1);
  assign win  = NREQ'({pick, pick} >> (NREQ - int'(ptr)));
`endif

endmodule

// File: rtl/sdram_read_arbiter.sv
// Shares one SDRAM read-command port among NREQ requesters with periodic auto-refresh; cmd_valid
// one clock after req in IDLE, holds while cmd_ready low. SDRAM_ARB_FIXED_PRIO_EN selects strict priority.
module sdram_read_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ           = 2,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int BURST_LEN      = BURST_LEN_DEF,
  parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEF
) (
  input logic                 clk,
  input logic                 reset_n,
  sdram_read_arbiter_if.master bus
);

  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [RW-1:0] REF_RELOAD = RW'(REFRESH_CYCLES - 1);

  arb_state_t        state;
  logic [RW-1:0]     ref_cnt;
  logic              refresh_pending;
  logic              overrun_q;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  next_ptr;
  logic [3:0]        beat_cnt;
  logic              cmd_valid_q;
  logic              cmd_refresh_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [NREQ-1:0]   win;
  logic [IDX_W-1:0]  win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [NREQ-1:0]   owner_oh;
  logic              cmd_fire, read_accept, ref_accept, ref_expire, in_beat, last_beat;

  sdram_rr_picker #(.NREQ(NREQ)) u_picker (
    .req (bus.req),
    .ptr (rr_ptr),
    .win (win)
  );

  assign win_idx = onehot_to_idx(MAX_NREQ'(win));

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_addr = win_addr | bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign next_ptr = '0;
`else
  assign next_ptr = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
`endif

  assign cmd_fire    = cmd_valid_q & bus.cmd_ready;
  assign read_accept = cmd_fire & ~cmd_refresh_q;
  assign ref_accept  = cmd_fire & cmd_refresh_q;
  assign ref_expire  = (ref_cnt == '0);
  assign owner_oh    = NREQ'(1) << owner;
  assign in_beat     = (state == BURST) & bus.rsp_valid;
  assign last_beat   = in_beat & (beat_cnt == 4'(BURST_LEN - 1));

  assign bus.gnt             = read_accept ? owner_oh : '0;
  assign bus.rd_valid        = in_beat ? owner_oh : '0;
  assign bus.rd_data         = in_beat ? bus.rsp_data : '0;
  assign bus.rd_last         = last_beat;
  assign bus.cmd_valid       = cmd_valid_q;
  assign bus.cmd_refresh     = cmd_refresh_q;
  assign bus.cmd_addr        = cmd_addr_q;
  assign bus.busy            = (state != IDLE);
  assign bus.refresh_overrun = overrun_q;

  // an expiry landing on the accept cycle re-arms the request rather than counting as overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt         <= REF_RELOAD;
      refresh_pending <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      ref_cnt <= ref_expire ? REF_RELOAD : ref_cnt - 1'b1;
      if (ref_expire)      refresh_pending <= 1'b1;
      else if (ref_accept) refresh_pending <= 1'b0;
      if (ref_expire && refresh_pending && !ref_accept) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner         <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_refresh_q <= 1'b0;
      cmd_addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (refresh_pending) begin
            state         <= REFRESH;
            cmd_valid_q   <= 1'b1;
            cmd_refresh_q <= 1'b1;
            cmd_addr_q    <= '0;
          end else if (|bus.req) begin
            state         <= ISSUE;
            cmd_valid_q   <= 1'b1;
            cmd_refresh_q <= 1'b0;
            cmd_addr_q    <= win_addr;
            owner         <= win_idx;
          end
        end
        ISSUE: begin
          if (bus.cmd_ready) begin
            state       <= BURST;
            cmd_valid_q <= 1'b0;
            beat_cnt    <= '0;
            rr_ptr      <= next_ptr;
          end
        end
        BURST: begin
          if (bus.rsp_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) state <= IDLE;
          end
        end
        REFRESH: begin
          if (bus.cmd_ready) begin
            state         <= IDLE;
            cmd_valid_q   <= 1'b0;
            cmd_refresh_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
